// File: rtl/instr_encoder.sv
// instr_encoder: turns field-level ARM-subset requests into 32-bit instruction
// words with a running word address. Data-processing immediates are fitted to
// the rotated-immediate form by trying one rotation per cycle.
//
// state  | meaning
// IDLE   | waiting for a request (req_ready high)
// SEARCH | trying rotation rot_cnt for a data-proc immediate
// HOLD   | presenting out_instr/out_addr until the consumer takes it
module instr_encoder #(
  parameter int unsigned          ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]    BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_class,
  input  logic [3:0]        req_cond,
  input  logic [5:0]        req_funct,
  input  logic [3:0]        req_rn,
  input  logic [3:0]        req_rd,
  input  logic [3:0]        req_rm,
  input  logic [31:0]       req_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  rot_cnt;
  logic [31:0] imm_q;
  logic [19:0] hdr_q;     // {cond, class, funct, rn, rd} of the pending search

  logic [19:0] req_hdr;
  logic        is_search;
  logic [31:0] direct_instr;
  logic        direct_err;
  logic [31:0] rotated;

  // Rotate left by s bits; the doubled word makes the wrap-around free.
  function automatic logic [31:0] rol(input logic [31:0] v, input logic [4:0] s);
    logic [63:0] t;
    t = {v, v} << s;
    return t[63:32];
  endfunction

  assign req_ready = (state == IDLE);
  assign req_hdr   = {req_cond, req_class, req_funct, req_rn, req_rd};
  assign is_search = (req_class == 2'b00) && req_funct[5];
  assign rotated   = rol(imm_q, {rot_cnt, 1'b0});

  // Single-cycle encodings for every request that does not need the search.
  always_comb begin
    direct_instr = {req_hdr, 8'b0, req_rm};
    direct_err   = 1'b0;
    unique case (req_class)
      2'b01: begin
        if (!req_funct[5]) begin
          direct_instr = {req_hdr, req_imm[11:0]};
          direct_err   = |req_imm[31:12];
        end
      end
      2'b10: begin
        direct_instr = {req_cond, 3'b101, req_funct[4], req_imm[23:0]};
        // Offset must be a sign-extended 24-bit value.
        direct_err   = !((&req_imm[31:23]) || !(|req_imm[31:23]));
      end
      default: direct_instr = {req_hdr, 8'b0, req_rm};
    endcase
  end

  // Control FSM with registered outputs; reset is synchronous and active low.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      err       <= 1'b0;
      out_instr <= '0;
      out_addr  <= BASE_ADDR;
      rot_cnt   <= '0;
      imm_q     <= '0;
      hdr_q     <= '0;
    end else begin
      err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            imm_q <= req_imm;
            hdr_q <= req_hdr;
            if (is_search) begin
              rot_cnt <= '0;
              state   <= SEARCH;
            end else if (direct_err) begin
              err <= 1'b1;
            end else begin
              out_instr <= direct_instr;
              out_valid <= 1'b1;
              state     <= HOLD;
            end
          end
        end
        SEARCH: begin
          if (rotated[31:8] == 24'd0) begin
            out_instr <= {hdr_q, rot_cnt, rotated[7:0]};
            out_valid <= 1'b1;
            state     <= HOLD;
          end else if (rot_cnt == 4'd15) begin
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            rot_cnt <= rot_cnt + 4'd1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_addr  <= out_addr + ADDR_W'(4);
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: the driver pushes the expected word or
// error event (with its expected cycle) into a queue, the monitor pops and
// compares whenever the DUT reports an error or completes an output handshake.
module tb_instr_encoder;
  localparam int unsigned   ADDR_W = 32;
  localparam logic [31:0]   BASE   = 32'h0;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_class = '0;
  logic [3:0]  req_cond = '0;
  logic [5:0]  req_funct = '0;
  logic [3:0]  req_rn = '0;
  logic [3:0]  req_rd = '0;
  logic [3:0]  req_rm = '0;
  logic [31:0] req_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        err;

  instr_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_class(req_class), .req_cond(req_cond), .req_funct(req_funct),
    .req_rn(req_rn), .req_rd(req_rd), .req_rm(req_rm), .req_imm(req_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_err;
    logic [31:0] instr;
    logic [31:0] addr;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          passed = 0;
  int          cyc = 0;
  logic [31:0] exp_addr = BASE;
  int          stall_left = 0;
  bit          rand_rdy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (ok) passed++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
  endtask

  // Reference model: encoding derived directly from the field rules.
  task automatic model(input logic [1:0] cls, input logic [3:0] cond, input logic [5:0] funct,
                       input logic [3:0] rn, input logic [3:0] rd, input logic [3:0] rm,
                       input logic [31:0] imm, output bit e, output logic [31:0] w, output int lat);
    logic [19:0] hdr;
    logic [63:0] t;
    logic [31:0] v;
    int          s;
    hdr = {cond, cls, funct, rn, rd};
    e = 1'b0;
    lat = 1;
    w = {hdr, 8'b0, rm};
    if (cls == 2'b00 && funct[5]) begin
      e = 1'b1;
      lat = 17;
      for (int r = 0; r < 16; r++) begin
        t = {32'b0, imm} << (2 * r);
        v = t[31:0] | t[63:32];
        if (e && v < 256) begin
          e = 1'b0;
          w = {hdr, 4'(r), v[7:0]};
          lat = 2 + r;
        end
      end
    end else if (cls == 2'b01 && !funct[5]) begin
      e = imm > 32'd4095;
      w = {hdr, imm[11:0]};
    end else if (cls == 2'b10) begin
      s = $signed(imm);
      e = !(s >= -(1 << 23) && s < (1 << 23));
      w = {cond, 3'b101, funct[4], imm[23:0]};
    end
  endtask

  // Drive one request; pushes the expected outcome and returns the accept cycle.
  task automatic issue(input logic [1:0] cls, input logic [3:0] cond, input logic [5:0] funct,
                       input logic [3:0] rn, input logic [3:0] rd, input logic [3:0] rm,
                       input logic [31:0] imm, input bit use_lit, input bit lit_err,
                       input logic [31:0] lit_instr, input int lit_lat, output int n);
    int   budget;
    bit   e;
    logic [31:0] w;
    int   lat;
    exp_t ent;
    budget = 0;
    n = 0;
    @(posedge clk); #1;
    while (!req_ready && budget < 200) begin
      @(posedge clk); #1;
      budget++;
    end
    if (!req_ready) begin
      chk(1'b0, "req_ready_timeout", 64'(req_ready), 64'd1);
      return;
    end
    req_class = cls; req_cond = cond; req_funct = funct;
    req_rn = rn; req_rd = rd; req_rm = rm; req_imm = imm;
    req_valid = 1'b1;
    n = cyc;
    model(cls, cond, funct, rn, rd, rm, imm, e, w, lat);
    if (use_lit) begin
      e = lit_err; w = lit_instr; lat = lit_lat;
    end
    ent.is_err = e;
    ent.instr  = w;
    ent.addr   = exp_addr;
    ent.cyc    = n + lat;
    q.push_back(ent);
    if (!e) exp_addr = exp_addr + 32'd4;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_imm = $urandom;
    req_rm = 4'($urandom);
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (q.size() != 0 && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    if (q.size() != 0) chk(1'b0, "drain_timeout", 64'(q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_state();
    @(negedge clk);
    chk(!out_valid && !err && req_ready && out_addr == BASE && out_instr == 32'd0, "reset_state",
        {29'd0, out_valid, err, req_ready, out_addr}, {29'd0, 3'b001, BASE});
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    q.delete();
    exp_addr = BASE;
    check_reset_state();
  endtask

  // Consumer-side backpressure.
  always @(posedge clk) begin
    #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    else if (out_valid && stall_left > 0) begin
      out_ready = 1'b0;
      stall_left--;
    end else out_ready = 1'b1;
  end

  // Monitor / scoreboard.
  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic [31:0] prev_instr = '0;
  logic [31:0] prev_addr = '0;
  int          rise_cyc = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      prev_valid = 1'b0;
    end else begin
      if (err || out_valid)
        chk(!(err && out_valid), "err_with_valid", {62'd0, err, out_valid}, 64'd0);
      if (prev_valid && !prev_ready)
        chk(out_valid && !req_ready && out_instr == prev_instr && out_addr == prev_addr, "hold_stable",
            {out_instr, out_addr}, {prev_instr, prev_addr});
      if (out_valid && !prev_valid) rise_cyc = cyc;
      if (err) begin
        if (q.size() == 0) chk(1'b0, "unexpected_err", 64'd1, 64'd0);
        else begin
          e = q.pop_front();
          chk(e.is_err, "err_kind", 64'd1, 64'(e.is_err));
          chk(cyc == e.cyc, "err_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk(1'b0, "unexpected_word", 64'(out_instr), 64'd0);
        else begin
          e = q.pop_front();
          chk(!e.is_err, "word_kind", 64'd0, 64'(e.is_err));
          chk(out_instr == e.instr, "instr", 64'(out_instr), 64'(e.instr));
          chk(out_addr == e.addr, "addr", 64'(out_addr), 64'(e.addr));
          chk(rise_cyc == e.cyc, "latency", 64'(rise_cyc), 64'(e.cyc));
        end
      end
      prev_valid = out_valid;
      prev_ready = out_ready;
      prev_instr = out_instr;
      prev_addr  = out_addr;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    logic [1:0]  cls;
    logic [5:0]  fn;
    logic [31:0] imm;
    logic [31:0] x;
    logic [63:0] t;

    repeat (2) @(posedge clk);
    do_reset();

    // ADD R1,R2,#0xFF000000 -> rotation 4
    issue(2'b00, 4'hE, 6'b101000, 4'd2, 4'd1, 4'd0, 32'hFF000000, 1, 0, 32'hE28214FF, 6, n);
    drain();

    // ADD R0,R0,#5 then LDR R3,[R4,#8]
    do_reset();
    issue(2'b00, 4'hE, 6'b101000, 4'd0, 4'd0, 4'd0, 32'h5, 1, 0, 32'hE2800005, 2, n);
    issue(2'b01, 4'hE, 6'b011001, 4'd4, 4'd3, 4'd0, 32'h8, 1, 0, 32'hE5943008, 1, n);
    drain();

    // Unencodable immediate: err exactly 17 cycles after acceptance
    issue(2'b00, 4'hE, 6'b101000, 4'd0, 4'd0, 4'd0, 32'h101, 1, 1, 32'h0, 17, n);
    do @(negedge clk); while (cyc < n + 18);
    chk(req_ready && out_addr == exp_addr, "search_err_idle", {31'd0, req_ready, out_addr}, {32'd1, exp_addr});
    drain();

    // Branches
    issue(2'b10, 4'hE, 6'b000000, 4'd0, 4'd0, 4'd0, 32'hFFFFFFFE, 1, 0, 32'hEAFFFFFE, 1, n);
    issue(2'b10, 4'hE, 6'b000000, 4'd0, 4'd0, 4'd0, 32'h01000000, 1, 1, 32'h0, 1, n);
    drain();

    // Backpressure for three cycles
    stall_left = 3;
    issue(2'b01, 4'hE, 6'b011001, 4'd4, 4'd3, 4'd0, 32'h8, 0, 0, 32'h0, 0, n);
    drain();
    issue(2'b00, 4'h1, 6'b001001, 4'd5, 4'd6, 4'd7, 32'h0, 0, 0, 32'h0, 0, n);
    drain();

    // Reset in the middle of a search at rotation 3
    issue(2'b00, 4'hE, 6'b101000, 4'd2, 4'd1, 4'd0, 32'hFF000000, 0, 0, 32'h0, 0, n);
    while (cyc < n + 4) begin
      @(posedge clk); #1;
    end
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    q.delete();
    exp_addr = BASE;
    check_reset_state();
    issue(2'b00, 4'hE, 6'b101000, 4'd0, 4'd0, 4'd0, 32'h5, 1, 0, 32'hE2800005, 2, n);
    drain();

    // Randomized traffic with random backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 150; i++) begin
      cls = 2'($urandom_range(0, 3));
      fn  = 6'($urandom);
      imm = $urandom;
      case (cls)
        2'b00: begin
          if (fn[5] && $urandom_range(0, 3) != 0) begin
            t = {56'd0, 8'($urandom_range(0, 255))} << (2 * $urandom_range(0, 15));
            imm = t[31:0] | t[63:32];
          end
        end
        2'b01: if ($urandom_range(0, 4) != 0) imm = $urandom_range(0, 4095);
        2'b10: begin
          if ($urandom_range(0, 3) != 0) begin
            x = $urandom;
            imm = {{8{x[23]}}, x[23:0]};
          end
        end
        default: ;
      endcase
      issue(cls, 4'($urandom), fn, 4'($urandom), 4'($urandom), 4'($urandom), imm, 0, 0, 32'h0, 0, n);
    end
    drain();
    rand_rdy = 1'b0;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Sequential ARM-subset instruction encoder, the inverse of the core's instruction decoder.
- Takes field-level requests (class, cond, funct, registers, immediate) over a valid/ready handshake and emits 32-bit instruction words with an auto-incrementing word address.
- Feeds the instruction-memory load/test path.
- Searches iteratively for the data-processing rotated-immediate encoding, one rotation per cycle.

Parameters:
ADDR_W, 32, width of out_addr.
BASE_ADDR, 0, out_addr value after reset; must be a multiple of 4.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
req_valid  in  1  request present.
req_ready  out  1  encoder can accept a request.
req_class  in  2  instr[27:26]: 00 data-proc, 01 memory, 10 branch, 11 multiply/extension.
req_cond  in  4  condition field, instr[31:28].
req_funct  in  6  instr[25:20]. Data-proc: {I,cmd,S}. Memory: {~I,P,U,B,W,L}. Branch: only bit 4 (L) is used.
req_rn  in  4  Rn, instr[19:16].
req_rd  in  4  Rd, instr[15:12].
req_rm  in  4  Rm, instr[3:0], for register forms.
req_imm  in  32  immediate. Data-proc: 32-bit value. Memory: offset. Branch: signed word offset.
out_valid  out  1  out_instr/out_addr are valid.
out_ready  in  1  consumer accepts the word.
out_instr  out  32  encoded instruction.
out_addr  out  ADDR_W  address of out_instr.
err  out  1  one-cycle pulse when a request is unencodable; that request is dropped.

Behaviour:
- States: IDLE, SEARCH, HOLD.
- req_ready = 1 only in IDLE. A request is accepted when req_valid & req_ready; all request fields are registered on acceptance.
- Reset (reset=0 at a clock edge) forces, from any state including mid-SEARCH or HOLD:
  - state IDLE, out_valid 0, err 0
  - out_instr 0, out_addr BASE_ADDR
  - rotation counter 0; any pending request is discarded.
- Encoding, with low field instr[11:0]:
  - Data-proc, funct[5]=1: low = {rot, imm8}. rot is the smallest value in 0..15 such that ROL(req_imm, 2*rot)[31:8] == 0; imm8 = ROL(req_imm, 2*rot)[7:0].
  - Data-proc, funct[5]=0, and class 11: low = {8'b0, rm}.
  - Memory, funct[5]=0: low = req_imm[11:0]. err if req_imm[31:12] != 0.
  - Memory, funct[5]=1: low = {8'b0, rm}.
  - Branch: instr = {cond, 3'b101, funct[4], req_imm[23:0]}. err unless req_imm[31:24] is all copies of req_imm[23].
  - All other classes: instr = {cond, class, funct, rn, rd, low}.
- Latency and state flow:
  - Non-search request accepted in cycle N: enters HOLD, out_valid=1 in cycle N+1. An error request instead pulses err in N+1 and returns to IDLE.
  - Data-proc immediate: enters SEARCH; rotation k is tested in cycle N+1+k.
    - Match at k: HOLD, out_valid in cycle N+2+k.
    - No match after k=15: err in cycle N+17, then IDLE. No output, no address change.
- HOLD:
  - out_instr and out_addr stay stable while out_ready=0.
  - On out_valid & out_ready: out_addr += 4 (wraps modulo 2^ADDR_W), out_valid drops, state returns to IDLE.
  - The next request can be accepted in the cycle after the handshake; there is no back-to-back acceptance.
- err is never asserted together with out_valid.

Test Plan:
- Reset, then encode ADD R1,R2,#0xFF000000: class 00, cond E, funct 101000, rn 2, rd 1, imm 0xFF000000, accepted at cycle N -> out_valid at N+6, out_instr 0xE28214FF, out_addr 0x0.
- Encode ADD R0,R0,#5 (rot 0), then LDR R3,[R4,#8] (class 01, funct 011001, rn 4, rd 3, imm 8), with out_ready=1:
  - first word: out_valid at N+2, out_instr 0xE2800005, out_addr 0x0.
  - LDR: out_valid one cycle after acceptance, out_instr 0xE5943008, out_addr 0x4.
- Unencodable data-proc immediate 0x00000101 -> err high exactly in cycle N+17, out_valid stays 0, out_addr unchanged, req_ready=1 at N+18.
- Branches:
  - class 10, cond E, funct[4]=0, imm 0xFFFFFFFE -> out_instr 0xEAFFFFFE.
  - imm 0x01000000 -> err at N+1, no output.
- Backpressure: hold out_ready=0 for 3 cycles during HOLD -> out_instr and out_addr stable, req_ready=0, out_addr increments by 4 only on the handshake cycle.
- Drive reset=0 during SEARCH (k=3) -> next cycle: IDLE, out_valid 0, err 0, out_addr BASE_ADDR; a fresh request then encodes normally.
